// File: rtl/rc4_mem_pkg.sv
// Shared types and defaults for the RC4 S-memory arbiter slice.
package rc4_mem_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int NUM_REQ_DEF = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(NUM_REQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/s_mem_arbiter_if.sv
// Requester-side bus of the S-memory arbiter: packed per-requester
// request/lock/beat fields plus grant and routed read return.
interface s_mem_arbiter_if
  import rc4_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AW      = rc4_mem_pkg::ADDR_W,
  parameter int DW      = rc4_mem_pkg::DATA_W
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    wren_in;
  logic [NUM_REQ*AW-1:0] addr_in;
  logic [NUM_REQ*DW-1:0] wdata_in;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdata;

  modport master (
    output req, lock, wren_in, addr_in, wdata_in,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, wren_in, addr_in, wdata_in,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/s_mem_arbiter_pick.sv
// Combinational winner selection: first requesting index at or after the
// pointer, wrapping. A pointer tied to zero gives lowest-index priority.
module arb_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  localparam int unsigned N = NUM_REQ;

  // Scan from the pointer and keep the first requester found.
  always_comb begin
    int unsigned w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = IDX_W'(w_cand);
      end
    end
  end
endmodule

// File: rtl/s_mem_arbiter.sv
// S-memory arbiter: grants the single-port RAM to one RC4 phase at a time,
// holds ownership across locked beats so a swap stays atomic, and routes
// each read result back to the requester that issued it.
// Optional: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise lowest requesting index wins.
module s_mem_arbiter
  import rc4_mem_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = rc4_mem_pkg::ADDR_W,
  parameter int DATA_W  = rc4_mem_pkg::DATA_W,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  s_mem_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata;
  logic [RD_LAT-1:0]  r_tag_v;
  logic [IDX_W-1:0]   r_tag_id [RD_LAT];

  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr;
  logic               w_own_req;
  logic               w_own_lock;
  logic               w_own_wren;
  logic [ADDR_W-1:0]  w_own_addr;
  logic [DATA_W-1:0]  w_own_wdata;
  logic               w_busy;
  logic               w_accept;
  logic               w_release;
  logic               w_grant;

  assign w_own_req   = bus.req[r_owner];
  assign w_own_lock  = bus.lock[r_owner];
  assign w_own_wren  = bus.wren_in[r_owner];
  assign w_own_addr  = bus.addr_in[32'(r_owner)*ADDR_W +: ADDR_W];
  assign w_own_wdata = bus.wdata_in[32'(r_owner)*DATA_W +: DATA_W];

  assign w_busy    = (r_state == ARB_BUSY);
  // Beats are suppressed during reset so nothing reaches the RAM or the tag pipe.
  assign w_accept  = w_busy & w_own_req & r_gnt[r_owner] & ~reset;
  // Dropping req releases even when lock is held.
  assign w_release = w_busy & (~w_own_req | (w_accept & ~w_own_lock));
  assign w_grant   = ~reset & w_any & (~w_busy | w_release);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  // Pointer moves just past each new winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (32'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (w_ptr),
    .o_gnt (w_win_oh),
    .o_idx (w_win_idx),
    .o_any (w_any)
  );

  // Ownership FSM; the release cycle re-arbitrates so a waiting requester gets no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_BUSY;
            r_owner <= w_win_idx;
            r_gnt   <= w_win_oh;
          end else begin
            r_gnt <= '0;
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            if (w_any) begin
              r_owner <= w_win_idx;
              r_gnt   <= w_win_oh;
            end else begin
              r_state <= ARB_IDLE;
              r_gnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // RAM port follows the owner; strobes only on an accepted beat.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    if (w_busy) begin
      ram_address = w_own_addr;
      ram_data    = w_own_wdata;
      ram_wren    = w_accept & w_own_wren;
      ram_rden    = w_accept & ~w_own_wren;
    end
  end

  // Read tags travel alongside the RAM latency so results reach their issuer across handoffs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_tag_v[0]  <= w_accept & ~w_own_wren;
      r_tag_id[0] <= r_owner;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_rvalid <= '0;
      if (r_tag_v[RD_LAT-1]) begin
        r_rvalid[r_tag_id[RD_LAT-1]] <= 1'b1;
        r_rdata                      <= ram_q;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
endmodule

// File: tb/tb_s_mem_arbiter.sv
// Scoreboard bench for s_mem_arbiter: queued requester transactions,
// a behavioural RAM, a spec-level grant/memory model and a read-return monitor.
module tb_s_mem_arbiter;
  import rc4_mem_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  s_mem_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          ram_rden;
  logic [DW-1:0] ram_q;

  s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q)
  );

  // Behavioural single-port RAM with LAT-cycle read latency.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] q_pipe  [LAT];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    if (ram_rden) q_pipe[0] <= ram_mem[ram_address];
    for (int k = 1; k < LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign ram_q = q_pipe[LAT-1];

  typedef struct {
    bit         wr;
    bit         lock;
    bit         first;
    logic [7:0] addr;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    longint     due;
  } exp_t;

  beat_t rq [N][$];
  exp_t  sb [$];

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     mon_en   = 0;
  bit     gap_en   = 0;
  bit     clear_pending = 0;
  int     rst_age  = 0;
  int     last_acc = -1;

  logic [N-1:0]    exp_gnt = '0;
  int              m_owner = -1;
  int              m_ptr   = 0;
  int              in_txn  = -1;
  logic [7:0]      ref_mem [256];

  logic [N-1:0]    dr_req, dr_lock, dr_wren;
  logic [N*AW-1:0] dr_addr;
  logic [N*DW-1:0] dr_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Spec rule: first requesting index at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !(gap_en && rq[i][0].first && $urandom_range(0, 3) == 0)) begin
        dr_req[i]              = 1'b1;
        dr_lock[i]             = rq[i][0].lock;
        dr_wren[i]             = rq[i][0].wr;
        dr_addr[i*AW +: AW]    = rq[i][0].addr;
        dr_wdata[i*DW +: DW]   = rq[i][0].data;
      end else begin
        dr_req[i]              = 1'b0;
        dr_lock[i]             = 1'($urandom_range(0, 1));
        dr_wren[i]             = 1'($urandom_range(0, 1));
        dr_addr[i*AW +: AW]    = 8'($urandom);
        dr_wdata[i*DW +: DW]   = 8'($urandom);
      end
    end
    bus.req      = dr_req;
    bus.lock     = dr_lock;
    bus.wren_in  = dr_wren;
    bus.addr_in  = dr_addr;
    bus.wdata_in = dr_wdata;
  endtask

  // Evaluated mid-cycle: inputs and grant are stable for the coming edge.
  task automatic model_step();
    int    acc;
    int    w;
    beat_t b;
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    if (reset) begin
      if (rst_age > 0) begin
        check("ram_wren_in_reset", 32'(ram_wren), 32'd0);
        check("rvalid_in_reset", 32'(bus.rvalid), 32'd0);
      end
      exp_gnt = '0; m_owner = -1; m_ptr = 0; in_txn = -1;
      clear_pending = 1; last_acc = -1;
      return;
    end
    acc = -1;
    for (int i = 0; i < N; i++) if (exp_gnt[i] && dr_req[i]) acc = i;
    last_acc = acc;
    if (acc >= 0) begin
      b = rq[acc].pop_front();
      if (in_txn >= 0) check("atomic_owner", 32'(acc), 32'(in_txn));
      in_txn = b.lock ? acc : -1;
      if (b.wr) ref_mem[b.addr] = b.data;
      else sb.push_back('{id: acc, data: ref_mem[b.addr], due: cyc + LAT + 1});
    end
    if (m_owner < 0 || !dr_req[m_owner] || (acc == m_owner && !dr_lock[m_owner])) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      w = pick(dr_req, m_ptr);
`else
      w = pick(dr_req, 0);
`endif
      if (w >= 0) begin
        exp_gnt = N'(1 << w); m_owner = w; m_ptr = (w + 1) % N;
      end else begin
        exp_gnt = '0; m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    rst_age = reset ? rst_age + 1 : 0;
    if (clear_pending) begin
      sb.delete();
      clear_pending = 0;
    end
    drive();
  endtask

  function automatic bit idle();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 0;
    return (sb.size() == 0) && (m_owner < 0);
  endfunction

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (!idle()) begin
      if (c == maxc) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: not idle after %0d cycles, expected idle", maxc);
        return;
      end
      cycle();
      c++;
    end
  endtask

  function automatic beat_t mk(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               input bit lk, input bit first);
    beat_t b;
    b.wr = wr; b.addr = a; b.data = d; b.lock = lk; b.first = first;
    return b;
  endfunction

  // Read-return monitor: pops one expectation per rvalid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_checks++; n_fail++;
        $display("FAIL rvalid_missing: requester %0d got nothing, expected data %0h at cyc %0d",
                 sb[0].id, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      if (bus.rvalid !== '0) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_route", 32'(bus.rvalid), 32'(1) << e.id);
          check("rdata", 32'(bus.rdata), 32'(e.data));
          check("read_latency_cyc", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = 8'($urandom);
      ram_mem[a] = ref_mem[a];
    end
    for (int k = 0; k < LAT; k++) q_pipe[k] = '0;

    // Reset with every requester asserting.
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].push_back(mk(0, 8'(8'h60 + i), 8'h00, 0, 1));
    drive();
    @(posedge clk);
    #1;
    rst_age = 1;
    mon_en  = 1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    check("gnt_after_reset", 32'(bus.gnt), 32'b001);
    wait_idle(50);

    // Two lower-priority requesters contending.
    rq[1].push_back(mk(0, 8'h21, 8'h00, 0, 1));
    rq[2].push_back(mk(0, 8'h22, 8'h00, 0, 1));
    drive();
    wait_idle(50);

    // Locked swap by requester 1 while requester 0 waits.
    rq[1].push_back(mk(0, 8'h05, 8'h00, 1, 1));
    rq[1].push_back(mk(0, 8'h1A, 8'h00, 1, 0));
    rq[1].push_back(mk(1, 8'h05, 8'h33, 1, 0));
    rq[1].push_back(mk(1, 8'h1A, 8'h77, 0, 0));
    drive();
    cycle();
    rq[0].push_back(mk(0, 8'h30, 8'h00, 0, 1));
    rq[0].push_back(mk(0, 8'h31, 8'h00, 0, 1));
    drive();
    wait_idle(50);
    rq[2].push_back(mk(0, 8'h05, 8'h00, 0, 1));
    rq[2].push_back(mk(0, 8'h1A, 8'h00, 0, 1));
    drive();
    wait_idle(50);

    // Read routing across a handoff, including write-then-read.
    rq[0].push_back(mk(1, 8'h10, 8'hAB, 0, 1));
    drive();
    wait_idle(50);
    rq[2].push_back(mk(0, 8'h10, 8'h00, 0, 1));
    drive();
    cycle();
    rq[0].push_back(mk(0, 8'h20, 8'h00, 0, 1));
    drive();
    wait_idle(50);

    // All requesters held with back-to-back unlocked beats.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) rq[i].push_back(mk(0, 8'(8'h50 + 4*i + k), 8'h00, 0, 1));
    drive();
    wait_idle(100);

    // Reset one cycle after a locked read is accepted.
    rq[1].push_back(mk(0, 8'h40, 8'h00, 1, 1));
    rq[1].push_back(mk(0, 8'h41, 8'h00, 1, 0));
    rq[1].push_back(mk(0, 8'h42, 8'h00, 0, 0));
    drive();
    for (int c = 0; c < 20 && last_acc != 1; c++) cycle();
    check("midop_read_accepted", 32'(last_acc), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive();
    cycle();
    cycle();
    check("gnt_midop_reset", 32'(bus.gnt), 32'd0);
    reset = 1'b0;
    drive();
    repeat (4) cycle();
    wait_idle(20);

    // Randomized transactions with idle gaps and address reuse.
    gap_en = 1;
    for (int t = 0; t < 150; t++) begin
      int r;
      int len;
      r   = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++)
        rq[r].push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                           (k < len - 1), (k == 0)));
    end
    drive();
    wait_idle(5000);
    gap_en = 0;
    drive();
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
